// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: configurable data/parity/stop bits, run-time
// bit period, valid/ready input with gapless back-to-back frames.
module uart_tx_cfg #(
    parameter int CLOCK_FREQUENCY = 200_000_000,
    parameter int BAUD_RATE       = 115200,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1,
    parameter int DIV_WIDTH       = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    input  logic [DATA_BITS-1:0] i_tx_data,
    output logic                 o_uart_tx,
    output logic                 o_uart_busy,
    output logic                 o_frame_done
);
    localparam int DEFAULT_DIV = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int IDXW        = $clog2(DATA_BITS + 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 3) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1..3");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (DEFAULT_DIV >= (1 << DIV_WIDTH)) begin : g_bad_div
        $error("uart_tx_cfg: DEFAULT_DIV does not fit in DIV_WIDTH");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0]        bit_q, bit_d;
    logic [1:0]             stop_q, stop_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   par_q, par_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, last_q, done_q;

    logic                   bit_end, stop_last, accept;
    logic [DIV_WIDTH-1:0]   eff_div;
    logic                   par_in;

    assign bit_end   = (cnt_q == div_q - DIV_WIDTH'(1));
    assign stop_last = (state_q == S_STOP) && bit_end && (stop_q == 2'(STOP_BITS - 1));
    assign accept    = i_tx_valid && o_tx_ready;
    assign eff_div   = (i_div <= DIV_WIDTH'(1)) ? DIV_WIDTH'(DEFAULT_DIV) : i_div;
    assign par_in    = (PARITY == 1) ? ~^i_tx_data : ^i_tx_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            div_q   <= DIV_WIDTH'(DEFAULT_DIV);
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            par_q   <= par_d;
            div_q   <= div_d;
            tx_q    <= tx_d;
            // Line, busy and done all trail the state by one clock.
            busy_q  <= (state_q != S_IDLE);
            last_q  <= stop_last;
            done_q  <= last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        data_d  = data_q;
        par_d   = par_q;
        div_d   = div_q;
        case (state_q)
            S_IDLE: ;
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else cnt_d = cnt_q + DIV_WIDTH'(1);
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d  = '0;
                    data_d = data_q >> 1;
                    if (bit_q == IDXW'(DATA_BITS - 1)) begin
                        stop_d  = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else bit_d = bit_q + IDXW'(1);
                end else cnt_d = cnt_q + DIV_WIDTH'(1);
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    stop_d  = '0;
                    state_d = S_STOP;
                end else cnt_d = cnt_q + DIV_WIDTH'(1);
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop_q == 2'(STOP_BITS - 1)) state_d = S_IDLE;
                    else stop_d = stop_q + 2'd1;
                end else cnt_d = cnt_q + DIV_WIDTH'(1);
            end
            default: state_d = S_IDLE;
        endcase
        // Accept only happens in IDLE or the final stop cycle; both lead to START.
        if (accept) begin
            data_d  = i_tx_data;
            par_d   = par_in;
            div_d   = eff_div;
            cnt_d   = '0;
            state_d = S_START;
        end
    end

    always_comb begin
        tx_d       = 1'b1;
        o_tx_ready = (state_q == S_IDLE) || stop_last;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_q[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    assign o_uart_tx    = tx_q;
    assign o_uart_busy  = busy_q;
    assign o_frame_done = done_q;
endmodule
